// File: rtl/fpdp_to_real_if.sv
// Handshake and result bundle for the double-to-fixed-point converter.
// The requester drives the operand and start; the converter returns results.
interface fpdp_to_real_if;
    logic [63:0] fpdp;
    logic        ready;
    logic [31:0] intg;
    logic [63:0] frac;
    logic        sign;
    logic        ovf;
    logic        nan;
    logic        busy;
    logic        done;

    modport master (
        output fpdp,
        output ready,
        input  intg,
        input  frac,
        input  sign,
        input  ovf,
        input  nan,
        input  busy,
        input  done
    );

    modport slave (
        input  fpdp,
        input  ready,
        output intg,
        output frac,
        output sign,
        output ovf,
        output nan,
        output busy,
        output done
    );
endinterface

// File: rtl/fpdp_to_real.sv
// IEEE-754 double to 32.64 unsigned fixed point plus sign, one shift per cycle.
// Special operands resolve in UNPACK and skip the shifter entirely.
module fpdp_to_real (
    input  logic          clk,
    input  logic          rset,
    fpdp_to_real_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        UNPACK = 2'd1,
        SHIFT  = 2'd2,
        FINISH = 2'd3
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [63:0] op_q;
    logic [95:0] wk_q;
    logic [6:0]  cnt_q;
    logic        sign_q;
    logic        ovf_q;
    logic        nan_q;
    logic        done_q;

    logic [10:0]        exp_w;
    logic [51:0]        man_w;
    logic signed [11:0] e_w;
    logic [11:0]        abs_e;
    logic               is_max;
    logic               is_nan;
    logic               is_inf;
    logic               is_zero;
    logic               is_big;
    logic               is_tiny;
    logic               is_sat;
    logic               is_special;
    logic [95:0]        wk_shift;

    assign exp_w = op_q[62:52];
    assign man_w = op_q[51:0];
    assign e_w   = $signed({1'b0, exp_w}) - 12'sd1023;
    assign abs_e = e_w[11] ? (~e_w + 12'd1) : e_w;

    assign is_max  = (exp_w == 11'h7FF);
    assign is_nan  = is_max && (man_w != 52'd0);
    assign is_inf  = is_max && (man_w == 52'd0);
    assign is_zero = (exp_w == 11'd0);
    assign is_big  = !is_max && (e_w > 12'sd31);
    assign is_tiny = !is_zero && (e_w < -12'sd64);
    assign is_sat  = is_inf || is_big;

    assign is_special = is_max || is_zero || is_big || is_tiny;

    // Direction follows the exponent sign; bits leaving the bottom are dropped.
    assign wk_shift = e_w[11] ? (wk_q >> 1) : (wk_q << 1);

    // State register.
    always_ff @(posedge clk or posedge rset) begin
        if (rset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state selection.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (bus.ready) begin
                    state_d = UNPACK;
                end
            end
            UNPACK: begin
                if (is_special || (e_w == 12'sd0)) begin
                    state_d = FINISH;
                end else begin
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (cnt_q <= 7'd1) begin
                    state_d = FINISH;
                end
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Operand capture, working register, flags and the done pulse.
    always_ff @(posedge clk or posedge rset) begin
        if (rset) begin
            op_q   <= '0;
            wk_q   <= '0;
            cnt_q  <= '0;
            sign_q <= 1'b0;
            ovf_q  <= 1'b0;
            nan_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (bus.ready) begin
                        op_q   <= bus.fpdp;
                        sign_q <= bus.fpdp[63];
                    end
                end
                UNPACK: begin
                    ovf_q <= is_sat;
                    nan_q <= is_nan;
                    if (is_sat) begin
                        wk_q <= '1;
                    end else if (is_special) begin
                        wk_q <= '0;
                    end else begin
                        wk_q <= {31'd0, 1'b1, man_w, 12'd0};
                    end
                    if (is_special) begin
                        cnt_q <= 7'd0;
                    end else begin
                        cnt_q <= abs_e[6:0];
                    end
                end
                SHIFT: begin
                    wk_q  <= wk_shift;
                    cnt_q <= cnt_q - 7'd1;
                end
                FINISH: begin
                    done_q <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.intg = wk_q[95:64];
    assign bus.frac = wk_q[63:0];
    assign bus.sign = sign_q;
    assign bus.ovf  = ovf_q;
    assign bus.nan  = nan_q;
    assign bus.busy = (state_q != IDLE);
    assign bus.done = done_q;
endmodule

// File: tb/tb_fpdp_to_real.sv
// Bench for fpdp_to_real: directed cases plus random operands
// checked against an arithmetic model of the double's exact value.
module tb_fpdp_to_real;
    logic clk;
    logic rset;

    fpdp_to_real_if bus ();

    fpdp_to_real dut (
        .clk  (clk),
        .rset (rset),
        .bus  (bus)
    );

    int n_checks;
    int n_errors;

    logic [31:0] obs_intg;
    logic [63:0] obs_frac;
    logic        obs_sign;
    logic        obs_ovf;
    logic        obs_nan;
    int          obs_lat;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [127:0] obs,
                            input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Exact value times 2^64 as an integer, then truncated into 32.64.
    task automatic ref_model(input logic [63:0] v,
                             output logic [31:0] mi,
                             output logic [63:0] mf,
                             output logic mo,
                             output logic mn,
                             output int lat);
        int          ex;
        int          e;
        int          sh;
        logic [127:0] m;
        logic [127:0] p;
        ex = int'(v[62:52]);
        e  = ex - 1023;
        mi = '0;
        mf = '0;
        mo = 1'b0;
        mn = 1'b0;
        lat = 2;
        if (ex == 2047) begin
            if (v[51:0] != 52'd0) begin
                mn = 1'b1;
            end else begin
                mo = 1'b1;
                mi = '1;
                mf = '1;
            end
        end else if (ex == 0) begin
            lat = 2;
        end else if (e > 31) begin
            mo = 1'b1;
            mi = '1;
            mf = '1;
        end else if (e < -64) begin
            lat = 2;
        end else begin
            m  = {75'd0, 1'b1, v[51:0]};
            sh = ex - 1075 + 64;
            if (sh >= 0) p = m << sh;
            else         p = m >> (-sh);
            mi  = p[95:64];
            mf  = p[63:0];
            lat = 2 + ((e < 0) ? -e : e);
        end
    endtask

    // Start one conversion now; wait for done with a cycle bound.
    task automatic run_op(input logic [63:0] v);
        logic got;
        bus.fpdp  = v;
        bus.ready = 1'b1;
        @(posedge clk);
        #1;
        bus.ready = 1'b0;
        bus.fpdp  = {$urandom, $urandom};
        check_eq("busy_after_start", 128'(bus.busy), 128'd1);
        check_eq("done_low_at_start", 128'(bus.done), 128'd0);
        got = 1'b0;
        obs_lat = 0;
        for (int k = 1; k <= 100; k++) begin
            if (!got) begin
                bus.ready = 1'b1;
                @(posedge clk);
                #1;
                bus.ready = 1'b0;
                if (bus.done) begin
                    got     = 1'b1;
                    obs_lat = k;
                end else if (!bus.busy) begin
                    bus.ready = 1'b0;
                end
            end
        end
        check_eq("done_seen", 128'(got), 128'd1);
        obs_intg = bus.intg;
        obs_frac = bus.frac;
        obs_sign = bus.sign;
        obs_ovf  = bus.ovf;
        obs_nan  = bus.nan;
        check_eq("busy_low_at_done", 128'(bus.busy), 128'd0);
    endtask

    task automatic run_and_model(input string tag, input logic [63:0] v);
        logic [31:0] mi;
        logic [63:0] mf;
        logic        mo;
        logic        mn;
        int          lat;
        ref_model(v, mi, mf, mo, mn, lat);
        run_op(v);
        check_eq({tag, "_intg"}, 128'(obs_intg), 128'(mi));
        check_eq({tag, "_frac"}, 128'(obs_frac), 128'(mf));
        check_eq({tag, "_sign"}, 128'(obs_sign), 128'(v[63]));
        check_eq({tag, "_ovf"}, 128'(obs_ovf), 128'(mo));
        check_eq({tag, "_nan"}, 128'(obs_nan), 128'(mn));
        check_eq({tag, "_lat"}, 128'(obs_lat), 128'(lat));
    endtask

    function automatic logic [63:0] rand_operand();
        logic [10:0] ex;
        logic [51:0] man;
        int          pick;
        man  = 52'({$urandom, $urandom});
        pick = int'($urandom_range(0, 9));
        if (pick == 0)      ex = 11'd0;
        else if (pick == 1) ex = 11'h7FF;
        else if (pick == 2) ex = 11'($urandom);
        else                ex = 11'($urandom_range(1023 - 70, 1023 + 34));
        if (pick == 1 && $urandom_range(0, 1) == 0) man = '0;
        return {1'($urandom), ex, man};
    endfunction

    initial begin
        logic saw_done;
        n_checks  = 0;
        n_errors  = 0;
        rset      = 1'b1;
        bus.fpdp  = '0;
        bus.ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_intg", 128'(bus.intg), 128'd0);
        check_eq("rst_frac", 128'(bus.frac), 128'd0);
        check_eq("rst_busy", 128'(bus.busy), 128'd0);
        check_eq("rst_done", 128'(bus.done), 128'd0);
        @(negedge clk);
        rset = 1'b0;

        run_and_model("one", 64'h3FF0000000000000);
        check_eq("one_intg_k", 128'(obs_intg), 128'd1);
        check_eq("one_frac_k", 128'(obs_frac), 128'd0);
        check_eq("one_lat_k", 128'(obs_lat), 128'd2);

        run_and_model("two5", 64'h4004000000000000);
        check_eq("two5_intg_k", 128'(obs_intg), 128'd2);
        check_eq("two5_frac_k", 128'(obs_frac), 128'h8000000000000000);
        check_eq("two5_lat_k", 128'(obs_lat), 128'd3);

        run_and_model("m075", 64'hBFE8000000000000);
        check_eq("m075_sign_k", 128'(obs_sign), 128'd1);
        check_eq("m075_frac_k", 128'(obs_frac), 128'hC000000000000000);
        check_eq("m075_lat_k", 128'(obs_lat), 128'd3);

        run_and_model("big", 64'h4202A05F20000000);
        check_eq("big_ovf_k", 128'(obs_ovf), 128'd1);
        check_eq("big_intg_k", 128'(obs_intg), 128'hFFFFFFFF);
        check_eq("big_frac_k", 128'(obs_frac), 128'hFFFFFFFFFFFFFFFF);
        check_eq("big_lat_k", 128'(obs_lat), 128'd2);

        run_and_model("qnan", 64'h7FF8000000000000);
        check_eq("qnan_nan_k", 128'(obs_nan), 128'd1);
        check_eq("qnan_intg_k", 128'(obs_intg), 128'd0);

        run_and_model("ninf", 64'hFFF0000000000000);
        run_and_model("nzero", 64'h8000000000000000);
        run_and_model("denorm", 64'h000FFFFFFFFFFFFF);
        run_and_model("em64", 64'h3BF0000000000000);
        check_eq("em64_frac_k", 128'(obs_frac), 128'd1);
        run_and_model("em65", 64'h3BEFFFFFFFFFFFFF);
        run_and_model("e31", 64'h41EFFFFFFFFFFFFF);
        run_and_model("e32", 64'h41F0000000000000);

        bus.fpdp  = 64'hC0F0000000000000;
        bus.ready = 1'b1;
        @(posedge clk);
        #1;
        bus.ready = 1'b0;
        repeat (6) @(posedge clk);
        @(negedge clk);
        rset = 1'b1;
        #1;
        check_eq("abort_intg", 128'(bus.intg), 128'd0);
        check_eq("abort_frac", 128'(bus.frac), 128'd0);
        check_eq("abort_sign", 128'(bus.sign), 128'd0);
        check_eq("abort_flags", 128'({bus.ovf, bus.nan}), 128'd0);
        check_eq("abort_busy", 128'(bus.busy), 128'd0);
        saw_done = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
            if (bus.done) saw_done = 1'b1;
        end
        check_eq("abort_no_done", 128'(saw_done), 128'd0);
        @(negedge clk);
        rset = 1'b0;
        run_and_model("half", 64'h3FE0000000000000);
        check_eq("half_frac_k", 128'(obs_frac), 128'h8000000000000000);
        check_eq("half_lat_k", 128'(obs_lat), 128'd3);

        for (int i = 0; i < 60; i++) begin
            run_and_model("rnd", rand_operand());
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/fpdp_to_real.md
FPDP_TO_REAL -- requirements
Module: fpdp_to_real

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on rising edge.
REQ-002 SHALL have port rset, input, 1 bit: asynchronous, active-high reset.
REQ-003 SHALL have port fpdp, input, 64 bits: IEEE-754 double-precision operand (sign 63, exponent 62:52, mantissa 51:0).
REQ-004 SHALL have port ready, input, 1 bit: start request; sampled only while idle.
REQ-005 SHALL have port intg, output, 32 bits: unsigned integer part of |value|.
REQ-006 SHALL have port frac, output, 64 bits: binary fraction of |value|, weight of bit i = 2^(i-64).
REQ-007 SHALL have port sign, output, 1 bit: copy of fpdp[63] for the converted operand.
REQ-008 SHALL have port ovf, output, 1 bit: |value| >= 2^32, or infinity.
REQ-009 SHALL have port nan, output, 1 bit: operand is NaN.
REQ-010 SHALL have port busy, output, 1 bit: conversion in progress.
REQ-011 SHALL have port done, output, 1 bit: one-cycle pulse when results are valid.

Function
REQ-012 SHALL implement FSM states IDLE, UNPACK, SHIFT, FINISH.
- IDLE -> UNPACK when ready=1.
- UNPACK -> FINISH for special cases, otherwise -> SHIFT, or -> FINISH directly when e=0.
- SHIFT -> FINISH when the shift count reaches 0.
- FINISH -> IDLE unconditionally.
REQ-013 SHALL latch fpdp in IDLE at the edge where ready=1; assert busy from the next cycle until IDLE is re-entered.
REQ-014 SHALL ignore ready and changes on fpdp while busy=1.
REQ-015 SHALL compute in UNPACK:
- e = exponent - 1023, as a signed 12-bit value.
- 96-bit working register {intg,frac} = {1,mantissa} placed at bits 64..12 (hidden bit at the binary point).
REQ-016 SHALL shift the working register one bit per SHIFT cycle: left e times if e>0, right -e times if e<0, zero-filling.
REQ-017 SHALL truncate bits shifted out on the right (magnitude rounds toward zero).
REQ-018 SHALL treat exponent=0 (zero or denormal) as result intg=0, frac=0, ovf=0, nan=0, with no SHIFT state.
REQ-019 SHALL treat e < -64 as result 0, with no SHIFT state.
REQ-020 SHALL treat e > 31 or exponent=2047 with mantissa=0 as saturation: intg=32'hFFFFFFFF, frac=all ones, ovf=1, with no SHIFT state.
REQ-021 SHALL treat exponent=2047 with mantissa!=0 as nan=1, intg=0, frac=0, ovf=0.
REQ-022 SHALL make sign equal the latched fpdp[63] for every case, including zero and NaN.
REQ-023 SHALL assert done for exactly one cycle while in FINISH.
REQ-024 SHALL make done rise 2+|e| rising edges after the sampling edge for shifted cases, and 2 edges for e=0 and special cases (max 66).
REQ-025 SHALL hold intg, frac, sign, ovf and nan stable from done until the next accepted start.
REQ-026 SHALL accept ready=1 in the cycle immediately after FINISH (back-to-back operation).
REQ-027 SHALL update intg and frac only in UNPACK, SHIFT and FINISH; they hold intermediate values while busy, and the bench checks them only at done.

Reset
REQ-028 SHALL, on rset=1, asynchronously force:
- state=IDLE;
- intg=0, frac=0, sign=0, ovf=0, nan=0, busy=0, done=0;
- shift count=0.
REQ-029 SHALL abort an in-progress conversion on rset, with no done pulse, and accept a new start on the first edge after rset deasserts.

Verification
REQ-030 SHALL pass: fpdp=64'h3FF0000000000000, ready pulse -> intg=1, frac=0, sign=0, done 2 edges after the sampling edge.
REQ-031 SHALL pass: fpdp=64'h4004000000000000 (2.5) -> intg=2, frac=64'h8000000000000000, done at 3 edges.
REQ-032 SHALL pass: fpdp=64'hBFE8000000000000 (-0.75) -> sign=1, intg=0, frac=64'hC000000000000000, done at 3 edges.
REQ-033 SHALL pass: fpdp=64'h4202A05F20000000 (1e10) -> ovf=1, intg=32'hFFFFFFFF, frac=all ones, done at 2 edges.
REQ-034 SHALL pass: fpdp=64'h7FF8000000000000 -> nan=1, intg=0, frac=0.
REQ-035 SHALL pass: fpdp=64'hC0F0000000000000 (e=16) started, rset pulsed mid-SHIFT -> all outputs 0, no done.
- Then start with 64'h3FE0000000000000 -> frac=64'h8000000000000000, done at 3 edges.
